bram_fifo: RTL

Synchronous first-word-fall-through FIFO on block RAM, with registered occupancy and almost-full/almost-empty status. It generalises the plain dual-port RAM into a buffered stream element. It sits between the Ethernet RX/TX byte pipelines and their packet parsers and framers. The write side is a push interface; the read side is a valid/ready interface with sustained throughput of 1 word/cycle.

---
 rtl/bram_fifo_pkg.sv | 14 +
 rtl/bram_sdp.sv | 22 ++
 rtl/bram_fifo.sv | 109 ++++++++++
 3 files changed

// File: rtl/bram_fifo_pkg.sv
// Shared defaults and the status bundle for bram_fifo and its parents.
package bram_fifo_pkg;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_DEPTH  = 16;

    typedef struct packed {
        logic full;
        logic empty;
        logic afull;
        logic aempty;
    } bram_fifo_status_t;

endpackage

// File: rtl/bram_sdp.sv
// Simple dual-port block RAM: one write port, one registered read port gated by rd_en.
module bram_sdp #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    (* ram_style="block" *) logic [DATA_W-1:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
        if (rd_en) rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/bram_fifo.sv
// First-word-fall-through FIFO on block RAM with a two-stage prefetch (RAM output, output register).
// Optional sticky overflow/underflow flags are built when BRAM_FIFO_ERR_EN is defined.
module bram_fifo
    import bram_fifo_pkg::*;
#(
    parameter int DATA_W    = DEF_DATA_W,
    parameter int DEPTH     = DEF_DEPTH,
    parameter int ADDR_W    = $clog2(DEPTH),
    parameter int AFULL_TH  = DEPTH - 2,
    parameter int AEMPTY_TH = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_wren,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic              i_rd_ready,
    output logic              o_rd_valid,
    output logic [DATA_W-1:0] o_rd_data,
    output logic [ADDR_W:0]   o_count,
    output logic              o_full,
    output logic              o_empty,
    output logic              o_almost_full,
    output logic              o_almost_empty
`ifdef BRAM_FIFO_ERR_EN
    ,
    output logic              o_overflow,
    output logic              o_underflow
`endif
);

    localparam int CW = ADDR_W + 1;
    localparam logic [CW-1:0] FULL_C   = CW'(DEPTH);
    localparam logic [CW-1:0] AFULL_C  = CW'(AFULL_TH);
    localparam logic [CW-1:0] AEMPTY_C = CW'(AEMPTY_TH);

    logic [ADDR_W-1:0] wptr, rptr;
    logic [CW-1:0]     count, unread;
    logic              s1_valid, out_valid;
    logic [DATA_W-1:0] ram_q, out_data;
    logic              push, pop, out_load, rd_en;
    bram_fifo_status_t status;

    assign status.full   = (count == FULL_C);
    assign status.empty  = (count == '0);
    assign status.afull  = (count >= AFULL_C);
    assign status.aempty = (count <= AEMPTY_C);

    // Unread RAM words exclude the two prefetch stages; entries written this cycle are not yet counted.
    assign unread   = count - CW'(s1_valid) - CW'(out_valid);
    assign push     = i_wren && !status.full;
    assign pop      = out_valid && i_rd_ready;
    assign out_load = s1_valid && (!out_valid || pop);
    assign rd_en    = (unread != '0) && (!s1_valid || out_load);

    bram_sdp #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_ram (
        .clk     (clk),
        .wr_en   (push),
        .wr_addr (wptr),
        .wr_data (i_wdata),
        .rd_en   (rd_en),
        .rd_addr (rptr),
        .rd_data (ram_q)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr      <= '0;
            rptr      <= '0;
            count     <= '0;
            s1_valid  <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            if (push)  wptr <= wptr + ADDR_W'(1);
            if (rd_en) rptr <= rptr + ADDR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            if (rd_en)         s1_valid <= 1'b1;
            else if (out_load) s1_valid <= 1'b0;
            if (out_load)      out_valid <= 1'b1;
            else if (pop)      out_valid <= 1'b0;
            if (out_load)      out_data <= ram_q;
        end
    end

`ifdef BRAM_FIFO_ERR_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            o_overflow  <= 1'b0;
            o_underflow <= 1'b0;
        end else begin
            if (i_wren && status.full)    o_overflow  <= 1'b1;
            if (i_rd_ready && !out_valid) o_underflow <= 1'b1;
        end
    end
`endif

    assign o_rd_valid     = out_valid;
    assign o_rd_data      = out_data;
    assign o_count        = count;
    assign o_full         = status.full;
    assign o_empty        = status.empty;
    assign o_almost_full  = status.afull;
    assign o_almost_empty = status.aempty;

endmodule
